// File: rtl/proc_regfile_pkg.sv
// Shared register-file sizing for the 4-stage core.
// Keeps rs/rd field widths and datapath width consistent.
package proc_regfile_pkg;
  localparam int REGFILE_WIDTH     = 8;
  localparam int REGFILE_ADDR_BITS = 3;
  localparam int REGFILE_ENTRIES   = 1 << REGFILE_ADDR_BITS;
  localparam int ZERO_ENTRY        = 0;
endpackage

// File: rtl/proc_regfile_if.sv
// Core <-> register-file bus plus debug/observation signals.
// master = core side, slave = register file.
interface proc_regfile_if
  import proc_regfile_pkg::*;
#(
  parameter int WIDTH     = REGFILE_WIDTH,
  parameter int ADDR_BITS = REGFILE_ADDR_BITS,
  parameter int CNT_WIDTH = 16
);
  logic                        ctrl_writeEnable;
  logic [ADDR_BITS-1:0]        ctrl_writeReg;
  logic [WIDTH-1:0]            data_writeReg;
  logic [ADDR_BITS-1:0]        ctrl_readReg;
  logic [WIDTH-1:0]            data_readReg;
  logic [ADDR_BITS-1:0]        dbg_readReg;
  logic [WIDTH-1:0]            dbg_data;
  logic [(1<<ADDR_BITS)-1:0]   written_mask;
  logic [CNT_WIDTH-1:0]        write_count;

  modport master (
    output ctrl_writeEnable, ctrl_writeReg, data_writeReg,
    output ctrl_readReg, dbg_readReg,
    input  data_readReg, dbg_data, written_mask, write_count
  );

  modport slave (
    input  ctrl_writeEnable, ctrl_writeReg, data_writeReg,
    input  ctrl_readReg, dbg_readReg,
    output data_readReg, dbg_data, written_mask, write_count
  );
endinterface

// File: rtl/proc_regfile_reg.sv
// Single WIDTH-bit register with write enable.
// Asynchronously cleared by an active-high reset.
module proc_regfile_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             we,
  input  logic [WIDTH-1:0] dataWrite,
  output logic [WIDTH-1:0] dataRead
);
  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      dataRead <= '0;
    else if (we)
      dataRead <= dataWrite;
  end
endmodule

// File: rtl/proc_regfile.sv
// Register file for the 4-stage core: combinational read with
// optional write bypass, debug read port, written mask, write counter.
module proc_regfile
  import proc_regfile_pkg::*;
#(
  parameter int WIDTH     = REGFILE_WIDTH,
  parameter int ADDR_BITS = REGFILE_ADDR_BITS,
  parameter int ZERO_REG  = 1,
  parameter int BYPASS    = 1,
  parameter int CNT_WIDTH = 16
) (
  input logic           clock,
  input logic           reset,
  proc_regfile_if.slave rf
);
  localparam int ENTRIES = 1 << ADDR_BITS;
  localparam logic [ADDR_BITS-1:0] R0 = ADDR_BITS'(ZERO_ENTRY);

  logic [ENTRIES-1:0] we_dec;
  logic [WIDTH-1:0]   q [ENTRIES];
  logic               accept;
  logic               rd_zero;
  logic               dbg_zero;
  logic               hit;

  // Writes to a hardwired zero entry are dropped entirely.
  assign accept = rf.ctrl_writeEnable &&
                  !(ZERO_REG != 0 && rf.ctrl_writeReg == R0);

  always_comb begin
    we_dec = '0;
    if (accept)
      we_dec[rf.ctrl_writeReg] = 1'b1;
  end

  for (genvar i = 0; i < ENTRIES; i++) begin : g_ent
    proc_regfile_reg #(.WIDTH(WIDTH)) u_reg (
      .clock     (clock),
      .reset     (reset),
      .we        (we_dec[i]),
      .dataWrite (rf.data_writeReg),
      .dataRead  (q[i])
    );
  end

  assign rd_zero  = (ZERO_REG != 0) && (rf.ctrl_readReg == R0);
  assign dbg_zero = (ZERO_REG != 0) && (rf.dbg_readReg == R0);
  assign hit      = (BYPASS != 0) && accept &&
                    (rf.ctrl_readReg == rf.ctrl_writeReg);

  always_comb begin
    rf.data_readReg = q[rf.ctrl_readReg];
    if (rd_zero)
      rf.data_readReg = '0;
    else if (hit)
      rf.data_readReg = rf.data_writeReg;
  end

  assign rf.dbg_data = dbg_zero ? '0 : q[rf.dbg_readReg];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rf.written_mask <= '0;
      rf.write_count  <= '0;
    end else begin
      rf.written_mask <= rf.written_mask | we_dec;
      if (accept && rf.write_count != '1)
        rf.write_count <= rf.write_count + 1'b1;
    end
  end
endmodule

// File: tb/tb_proc_regfile.sv
// Directed bench for proc_regfile: default instance plus a
// BYPASS=0 / CNT_WIDTH=4 instance driven with identical stimulus.
module tb_proc_regfile;
  logic clock = 1'b0;
  logic reset = 1'b1;
  int   passed = 0;
  int   total  = 0;

  always #5 clock = ~clock;

  proc_regfile_if #(.WIDTH(8), .ADDR_BITS(3), .CNT_WIDTH(16)) rf ();
  proc_regfile_if #(.WIDTH(8), .ADDR_BITS(3), .CNT_WIDTH(4))  rf2 ();

  proc_regfile #(
    .WIDTH(8), .ADDR_BITS(3), .ZERO_REG(1), .BYPASS(1), .CNT_WIDTH(16)
  ) dut (
    .clock (clock),
    .reset (reset),
    .rf    (rf)
  );

  proc_regfile #(
    .WIDTH(8), .ADDR_BITS(3), .ZERO_REG(1), .BYPASS(0), .CNT_WIDTH(4)
  ) dut2 (
    .clock (clock),
    .reset (reset),
    .rf    (rf2)
  );

  task automatic drive(input logic we, input logic [2:0] wa,
                       input logic [7:0] wd, input logic [2:0] ra,
                       input logic [2:0] da);
    rf.ctrl_writeEnable  = we;
    rf.ctrl_writeReg     = wa;
    rf.data_writeReg     = wd;
    rf.ctrl_readReg      = ra;
    rf.dbg_readReg       = da;
    rf2.ctrl_writeEnable = we;
    rf2.ctrl_writeReg    = wa;
    rf2.data_writeReg    = wd;
    rf2.ctrl_readReg     = ra;
    rf2.dbg_readReg      = da;
  endtask

  task automatic wr(input logic [2:0] wa, input logic [7:0] wd);
    @(negedge clock);
    drive(1'b1, wa, wd, wa, wa);
    @(negedge clock);
    drive(1'b0, wa, wd, wa, wa);
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    wr(3'd3, 8'h5A);
    #1;
    total++;
    if (rf.data_readReg !== 8'h5A) begin
      $display("FAIL pre_reset_r3 got %h want %h", rf.data_readReg, 8'h5A);
    end else passed++;
    #2;
    reset = 1'b1;
    #1;
    total++;
    if (rf.data_readReg !== 8'h00) begin
      $display("FAIL reset_read got %h want 00", rf.data_readReg);
    end else passed++;
    total++;
    if (rf.dbg_data !== 8'h00) begin
      $display("FAIL reset_dbg got %h want 00", rf.dbg_data);
    end else passed++;
    total++;
    if (rf.written_mask !== 8'h00) begin
      $display("FAIL reset_mask got %h want 00", rf.written_mask);
    end else passed++;
    total++;
    if (rf.write_count !== 16'd0 || rf2.write_count !== 4'd0) begin
      $display("FAIL reset_count got %0d/%0d want 0/0",
               rf.write_count, rf2.write_count);
    end else passed++;
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_basic();
    wr(3'd5, 8'hC3);
    #1;
    total++;
    if (rf.data_readReg !== 8'hC3) begin
      $display("FAIL basic_read got %h want c3", rf.data_readReg);
    end else passed++;
    total++;
    if (rf.written_mask !== 8'h20) begin
      $display("FAIL basic_mask got %h want 20", rf.written_mask);
    end else passed++;
    total++;
    if (rf.write_count !== 16'd1) begin
      $display("FAIL basic_count got %0d want 1", rf.write_count);
    end else passed++;
  endtask

  task automatic test_bypass();
    wr(3'd2, 8'h11);
    @(negedge clock);
    drive(1'b1, 3'd2, 8'h77, 3'd2, 3'd2);
    #1;
    total++;
    if (rf.data_readReg !== 8'h77) begin
      $display("FAIL bypass_read got %h want 77", rf.data_readReg);
    end else passed++;
    total++;
    if (rf.dbg_data !== 8'h11) begin
      $display("FAIL bypass_dbg got %h want 11", rf.dbg_data);
    end else passed++;
    total++;
    if (rf2.data_readReg !== 8'h11) begin
      $display("FAIL nobypass_read got %h want 11", rf2.data_readReg);
    end else passed++;
    @(posedge clock);
    #1;
    drive(1'b0, 3'd2, 8'h77, 3'd2, 3'd2);
    #1;
    total++;
    if (rf.data_readReg !== 8'h77 || rf.dbg_data !== 8'h77) begin
      $display("FAIL bypass_after got %h/%h want 77/77",
               rf.data_readReg, rf.dbg_data);
    end else passed++;
    total++;
    if (rf2.data_readReg !== 8'h77) begin
      $display("FAIL nobypass_after got %h want 77", rf2.data_readReg);
    end else passed++;
  endtask

  task automatic test_zero();
    @(negedge clock);
    drive(1'b1, 3'd0, 8'hFF, 3'd0, 3'd0);
    #1;
    total++;
    if (rf.data_readReg !== 8'h00 || rf.dbg_data !== 8'h00) begin
      $display("FAIL zero_same_cycle got %h/%h want 00/00",
               rf.data_readReg, rf.dbg_data);
    end else passed++;
    @(negedge clock);
    drive(1'b0, 3'd0, 8'hFF, 3'd0, 3'd0);
    #1;
    total++;
    if (rf.data_readReg !== 8'h00 || rf.dbg_data !== 8'h00) begin
      $display("FAIL zero_after got %h/%h want 00/00",
               rf.data_readReg, rf.dbg_data);
    end else passed++;
    total++;
    if (rf.written_mask !== 8'h24) begin
      $display("FAIL zero_mask got %h want 24", rf.written_mask);
    end else passed++;
    total++;
    if (rf.write_count !== 16'd3) begin
      $display("FAIL zero_count got %0d want 3", rf.write_count);
    end else passed++;
  endtask

  task automatic test_back_to_back();
    @(negedge clock);
    drive(1'b1, 3'd7, 8'h01, 3'd6, 3'd7);
    @(negedge clock);
    drive(1'b1, 3'd7, 8'h02, 3'd6, 3'd7);
    @(negedge clock);
    drive(1'b1, 3'd7, 8'h03, 3'd6, 3'd7);
    @(negedge clock);
    drive(1'b0, 3'd7, 8'h00, 3'd7, 3'd7);
    #1;
    total++;
    if (rf.data_readReg !== 8'h03 || rf.dbg_data !== 8'h03) begin
      $display("FAIL b2b_r7 got %h/%h want 03/03",
               rf.data_readReg, rf.dbg_data);
    end else passed++;
    total++;
    if (rf.write_count !== 16'd6) begin
      $display("FAIL b2b_count got %0d want 6", rf.write_count);
    end else passed++;
    total++;
    if (rf.written_mask !== 8'hA4) begin
      $display("FAIL b2b_mask got %h want a4", rf.written_mask);
    end else passed++;
  endtask

  task automatic test_saturation();
    do_reset();
    for (int i = 1; i <= 15; i++) begin
      @(negedge clock);
      drive(1'b1, 3'd4, 8'(i), 3'd4, 3'd4);
    end
    @(negedge clock);
    drive(1'b0, 3'd4, 8'h00, 3'd4, 3'd4);
    #1;
    total++;
    if (rf2.write_count !== 4'hF || rf.write_count !== 16'd15) begin
      $display("FAIL sat_15 got %0d/%0d want 15/15",
               rf2.write_count, rf.write_count);
    end else passed++;
    for (int i = 16; i <= 20; i++) begin
      @(negedge clock);
      drive(1'b1, 3'd4, 8'(i), 3'd4, 3'd4);
    end
    @(negedge clock);
    drive(1'b0, 3'd4, 8'h00, 3'd4, 3'd4);
    #1;
    total++;
    if (rf2.write_count !== 4'hF) begin
      $display("FAIL sat_hold got %h want f", rf2.write_count);
    end else passed++;
    total++;
    if (rf.write_count !== 16'd20) begin
      $display("FAIL sat_wide got %0d want 20", rf.write_count);
    end else passed++;
    total++;
    if (rf2.dbg_data !== 8'h14 || rf2.written_mask !== 8'h10) begin
      $display("FAIL sat_data got %h/%h want 14/10",
               rf2.dbg_data, rf2.written_mask);
    end else passed++;
  endtask

  task automatic test_pipeline();
    logic [7:0] v;
    do_reset();
    @(negedge clock);
    drive(1'b0, 3'd0, 8'h00, 3'd0, 3'd0);
    #1;
    v = rf.data_readReg + 8'd5;
    drive(1'b1, 3'd1, v, 3'd0, 3'd0);
    @(negedge clock);
    drive(1'b0, 3'd0, 8'h00, 3'd0, 3'd0);
    repeat (3) @(negedge clock);
    drive(1'b0, 3'd0, 8'h00, 3'd1, 3'd0);
    #1;
    v = rf.data_readReg + 8'd3;
    drive(1'b1, 3'd2, v, 3'd1, 3'd0);
    @(negedge clock);
    drive(1'b0, 3'd0, 8'h00, 3'd1, 3'd2);
    #1;
    total++;
    if (rf.data_readReg !== 8'h05) begin
      $display("FAIL pipe_r1 got %h want 05", rf.data_readReg);
    end else passed++;
    total++;
    if (rf.dbg_data !== 8'h08) begin
      $display("FAIL pipe_r2 got %h want 08", rf.dbg_data);
    end else passed++;
    total++;
    if (rf.written_mask !== 8'h06) begin
      $display("FAIL pipe_mask got %h want 06", rf.written_mask);
    end else passed++;
  endtask

  initial begin
    drive(1'b0, 3'd0, 8'h00, 3'd0, 3'd0);
    reset = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    test_reset();
    test_basic();
    test_bypass();
    test_zero();
    test_back_to_back();
    test_saturation();
    test_pipeline();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
